// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and constants for the registered one-hot decoder.
// The optional self-check (ONEHOT_DECODER_SEQ_CHECK_EN) also relies on these widths.
package onehot_pkg;

  localparam int ONEHOT_N = 8;
  localparam int ONEHOT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  function automatic logic [ONEHOT_N-1:0] onehot_of(input logic [ONEHOT_W-1:0] i);
    onehot_of    = '0;
    onehot_of[i] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Code handshake, mode controls and select outputs of onehot_decoder_seq.
// Master drives codes and modes; slave is the decoder.
interface onehot_decoder_seq_if;
  import onehot_pkg::*;

  logic [ONEHOT_W-1:0] code_in;
  logic                code_valid;
  logic                code_ready;
  logic                en;
  logic                scan_mode;
  logic [ONEHOT_N-1:0] o;
  logic [ONEHOT_W-1:0] idx;
  logic                step;

  modport master (
    output code_in, code_valid, en, scan_mode,
    input  code_ready, o, idx, step
  );

  modport slave (
    input  code_in, code_valid, en, scan_mode,
    output code_ready, o, idx, step
  );
endinterface

// File: rtl/onehot_decoder_seq_check.sv
// Combinational 8->3 encoder with a one-hot-valid flag; used by the optional
// consistency checker (ONEHOT_DECODER_SEQ_CHECK_EN) in onehot_decoder_seq.
module onehot_check
  import onehot_pkg::*;
(
  input  logic [ONEHOT_N-1:0] vec,
  output logic [ONEHOT_W-1:0] code,
  output logic                onehot
);

  always_comb begin
    code = '0;
    for (int i = 0; i < ONEHOT_N; i++) begin
      if (vec[i]) code = code | ONEHOT_W'(i);
    end
  end

  assign onehot = (vec != '0) && ((vec & (vec - ONEHOT_N'(1))) == '0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready code input and auto-scan.
// Optional sticky consistency checker enabled by ONEHOT_DECODER_SEQ_CHECK_EN.
module onehot_decoder_seq
  import onehot_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_decoder_seq_if.slave  bus
`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
  ,
  output logic                 chk_err
`endif
);

  localparam int                  PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]       PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [ONEHOT_N-1:0] O_IDLE     = ACTIVE_LOW ? '1 : '0;

  function automatic logic [ONEHOT_N-1:0] drive_line(input logic [ONEHOT_W-1:0] i);
    drive_line = ACTIVE_LOW ? ~onehot_of(i) : onehot_of(i);
  endfunction

  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [ONEHOT_W-1:0] idx_q, idx_d, idx_inc;
  logic [ONEHOT_N-1:0] o_q, o_d;
  logic                step_q, step_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      o_q     <= O_IDLE;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      o_q     <= o_d;
      step_q  <= step_d;
    end
  end

  assign idx_inc = idx_q + ONEHOT_W'(1);

  // Scan requests win over a code offered in the same cycle.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    o_d     = o_q;
    step_d  = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (bus.scan_mode) begin
            state_d = SCAN;
            presc_d = '0;
            if (state_q == IDLE) begin
              idx_d = '0;
              o_d   = drive_line('0);
            end
          end else if (bus.code_valid) begin
            state_d = HOLD;
            idx_d   = bus.code_in;
            o_d     = drive_line(bus.code_in);
          end
        end
        SCAN: begin
          if (!bus.scan_mode) begin
            state_d = HOLD;
            presc_d = '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_inc;
            o_d     = drive_line(idx_inc);
            step_d  = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.code_ready = !rst && bus.en && !bus.scan_mode && (state_q != SCAN);
  end

  assign bus.o    = o_q;
  assign bus.idx  = idx_q;
  assign bus.step = step_q;

`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
  logic [ONEHOT_N-1:0] norm_o;
  logic [ONEHOT_W-1:0] enc_idx;
  logic                enc_ok;
  logic                chk_err_q, chk_err_d;

  assign norm_o = ACTIVE_LOW ? ~o_q : o_q;

  onehot_check u_chk (
    .vec    (norm_o),
    .code   (enc_idx),
    .onehot (enc_ok)
  );

  // IDLE legitimately drives no line, so one-hotness is only demanded elsewhere.
  always_comb begin
    chk_err_d = chk_err_q | (enc_idx != idx_q) | ((state_q != IDLE) && !enc_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq: one active-high DUT (SCAN_DIV=4)
// and one active-low DUT (SCAN_DIV=1); checker tests under ONEHOT_DECODER_SEQ_CHECK_EN.
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_decoder_seq_if if1 ();
  onehot_decoder_seq_if if2 ();

`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
  logic chk1, chk2;
`endif

  onehot_decoder_seq #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
    ,
    .chk_err (chk1)
`endif
  );

  onehot_decoder_seq #(.SCAN_DIV(1), .ACTIVE_LOW(1'b1)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
    ,
    .chk_err (chk2)
`endif
  );

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] exp_o;
    logic [2:0] exp_idx;
  } vec_t;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] idx;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!if1.step && n < 50);
    if (!if1.step) n = -1;
  endtask

  initial begin
    vec_t tab [8];
    exp_t e;
    int   n;

    tab = '{
      '{3'd0, 8'h01, 3'd0}, '{3'd1, 8'h02, 3'd1}, '{3'd2, 8'h04, 3'd2}, '{3'd3, 8'h08, 3'd3},
      '{3'd4, 8'h10, 3'd4}, '{3'd5, 8'h20, 3'd5}, '{3'd6, 8'h40, 3'd6}, '{3'd7, 8'h80, 3'd7}
    };

    rst = 1'b1;
    if1.code_in = '0; if1.code_valid = 1'b0; if1.en = 1'b1; if1.scan_mode = 1'b0;
    if2.code_in = '0; if2.code_valid = 1'b0; if2.en = 1'b1; if2.scan_mode = 1'b0;

    // Reset held for two cycles
    repeat (2) begin
      cyc();
      check("rst_o", if1.o, 8'h00);
      check("rst_idx", if1.idx, 3'd0);
      check("rst_ready", if1.code_ready, 1'b0);
      check("rst_step", if1.step, 1'b0);
      check("rst_o_al", if2.o, 8'hFF);
    end
    rst = 1'b0;
    #1;
    check("post_rst_ready", if1.code_ready, 1'b1);

    // Direct decode, back-to-back handshakes
    for (int i = 0; i < 8; i++) begin
      if1.code_in    = tab[i].code;
      if1.code_valid = 1'b1;
      #1;
      check("dec_ready", if1.code_ready, 1'b1);
      sb.push_back('{tab[i].exp_o, tab[i].exp_idx});
      cyc();
      e = sb.pop_front();
      check("dec_o", if1.o, e.o);
      check("dec_idx", if1.idx, e.idx);
    end
    if1.code_valid = 1'b0;

    // Scan wrap from code 6
    if1.code_in = 3'd6; if1.code_valid = 1'b1;
    cyc();
    if1.code_valid = 1'b0;
    check("load6_o", if1.o, 8'h40);
    if1.scan_mode = 1'b1;
    #1;
    check("scanreq_ready", if1.code_ready, 1'b0);
    cyc();
    check("scan_entry_o", if1.o, 8'h40);
    check("scan_entry_idx", if1.idx, 3'd6);
    check("scan_entry_step", if1.step, 1'b0);
    wait_step(n);
    check("scan_period1", n, 4);
    check("scan_o7", if1.o, 8'h80);
    check("scan_idx7", if1.idx, 3'd7);
    wait_step(n);
    check("scan_period2", n, 4);
    check("scan_wrap_o", if1.o, 8'h01);
    check("scan_wrap_idx", if1.idx, 3'd0);
    cyc();
    check("step_single", if1.step, 1'b0);

    // Freeze with en low, prescaler sits at 1
    if1.en = 1'b0;
    #1;
    check("frz_ready", if1.code_ready, 1'b0);
    repeat (10) begin
      cyc();
      check("frz_o", if1.o, 8'h01);
      check("frz_step", if1.step, 1'b0);
    end
    if1.en = 1'b1;
    wait_step(n);
    check("frz_resume", n, 3);
    check("frz_next_o", if1.o, 8'h02);
    check("frz_next_idx", if1.idx, 3'd1);

    // Exit scan to HOLD
    if1.scan_mode = 1'b0;
    #1;
    check("exit_ready_scan", if1.code_ready, 1'b0);
    cyc();
    check("hold_o", if1.o, 8'h02);
    check("hold_idx", if1.idx, 3'd1);
    check("hold_ready", if1.code_ready, 1'b1);
    check("hold_step", if1.step, 1'b0);

    // Scan request and code in the same cycle
    if1.scan_mode = 1'b1; if1.code_valid = 1'b1; if1.code_in = 3'd3;
    #1;
    check("prio_ready", if1.code_ready, 1'b0);
    cyc();
    if1.code_valid = 1'b0;
    check("prio_o", if1.o, 8'h02);
    check("prio_idx", if1.idx, 3'd1);
    wait_step(n);
    check("prio_period", n, 4);
    check("prio_scan_o", if1.o, 8'h04);

    // Reset mid-scan with a pending code
    if1.code_valid = 1'b1; if1.code_in = 3'd5; rst = 1'b1;
    cyc();
    check("rst_scan_o", if1.o, 8'h00);
    check("rst_scan_idx", if1.idx, 3'd0);
    check("rst_scan_step", if1.step, 1'b0);
    check("rst_scan_ready", if1.code_ready, 1'b0);
    rst = 1'b0; if1.code_valid = 1'b0;
    cyc();
    check("idle_scan_o", if1.o, 8'h01);
    check("idle_scan_idx", if1.idx, 3'd0);
    wait_step(n);
    check("idle_scan_period", n, 4);
    check("idle_scan_o1", if1.o, 8'h02);
    if1.scan_mode = 1'b0;
    cyc();

    // Active-low DUT, scan every cycle
    if2.code_in = 3'd2; if2.code_valid = 1'b1;
    cyc();
    if2.code_valid = 1'b0;
    check("al_o", if2.o, 8'hFB);
    check("al_idx", if2.idx, 3'd2);
`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
    cyc();
    check("chk_clean", chk2, 1'b0);
`endif
    if2.scan_mode = 1'b1;
    cyc();
    check("al_entry_o", if2.o, 8'hFB);
    check("al_entry_step", if2.step, 1'b0);
    cyc();
    check("al_step1_o", if2.o, 8'hF7);
    check("al_step1", if2.step, 1'b1);
    cyc();
    check("al_step2_o", if2.o, 8'hEF);
    check("al_step2", if2.step, 1'b1);
    if2.scan_mode = 1'b0;
    cyc();
    check("al_hold_o", if2.o, 8'hEF);
    check("al_hold_step", if2.step, 1'b0);

`ifdef ONEHOT_DECODER_SEQ_CHECK_EN
    check("chk_before_flip", chk2, 1'b0);
    force u_dut2.o_q = 8'hEE;
    cyc();
    release u_dut2.o_q;
    cyc();
    check("chk_flip", chk2, 1'b1);
    repeat (3) cyc();
    check("chk_sticky", chk2, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("chk_rst", chk2, 1'b0);
    check("chk_other", chk1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
